// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring shift-subtract divider
//
// Purpose: divides a W-bit dividend by a W-bit divisor, one quotient bit per
// clock. Takes a start pulse and returns quotient and remainder with a
// single-cycle done pulse.
// Latency is W+1 cycles from the accepting edge, or 1 cycle for a zero
// divisor.
//
// Optional feature macro: SIGNED_DIV_EN
//   undefined: unsigned operands.
//   defined:   two's complement operands. The quotient truncates toward zero
//              and the remainder takes the sign of the dividend.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset; aborts any operation
//   start        request, sampled only while idle
//   dividend     W-bit numerator, captured on accepted start
//   divisor      W-bit denominator, captured on accepted start
//   quotient     W-bit registered quotient
//   remainder    W-bit registered remainder
//   busy         high from the accepting edge until the edge that raises done
//   done         single-cycle result strobe
//   div_by_zero  registered with done; captured divisor was zero
module seq_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIN
    } state_t;

    state_t         state;
    // Partial remainder. After each restore it is below B, so its top bit is
    // always zero. Only W bits are stored; the shift supplies the extra bit.
    logic [W-1:0]   acc;
    logic [W-1:0]   q;
    logic [W-1:0]   b;
    logic [CW-1:0]  cnt;
    logic           zero_flag;

    logic [W:0]     shifted;
    logic [W:0]     diff;
    logic [W-1:0]   q_final;
    logic [W-1:0]   r_final;

`ifdef SIGNED_DIV_EN
    logic           sign_q;
    logic           sign_r;

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        // -2^(W-1) maps onto itself, which reads correctly as an unsigned
        // magnitude.
        return v[W-1] ? (W'(0) - v) : v;
    endfunction
`endif

    // W+1 bit trial subtraction; diff[W] is the borrow (sign of T).
    always_comb begin
        shifted = {acc, q[W-1]};
        diff    = shifted - {1'b0, b};
    end

    // On a zero divisor no iterations run, so q still holds the captured
    // dividend (magnitude). It is returned as the remainder.
    always_comb begin
        q_final = zero_flag ? {W{1'b1}} : q;
        r_final = zero_flag ? q : acc;
`ifdef SIGNED_DIV_EN
        if (!zero_flag && sign_q) begin
            q_final = W'(0) - q;
        end
        if (sign_r) begin
            r_final = W'(0) - r_final;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            q           <= '0;
            b           <= '0;
            cnt         <= '0;
            zero_flag   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
`ifdef SIGNED_DIV_EN
                        q         <= mag(dividend);
                        b         <= mag(divisor);
                        sign_q    <= dividend[W-1] ^ divisor[W-1];
                        sign_r    <= dividend[W-1];
`else
                        q         <= dividend;
                        b         <= divisor;
`endif
                        cnt       <= CNT_INIT;
                        busy      <= 1'b1;
                        zero_flag <= (divisor == '0);
                        state     <= (divisor == '0) ? FIN : ITER;
                    end
                end
                ITER: begin
                    if (!diff[W]) begin
                        acc <= diff[W-1:0];
                        q   <= {q[W-2:0], 1'b1};
                    end else begin
                        // Restore: keep the shifted partial remainder, whose
                        // top bit is zero here because it is below B.
                        acc <= shifted[W-1:0];
                        q   <= {q[W-2:0], 1'b0};
                    end
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    quotient    <= q_final;
                    remainder   <= r_final;
                    div_by_zero <= zero_flag;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
